// File: rtl/ycc_to_rgb.sv
// ycc_to_rgb
//   Converts a fixed-point YCbCr pixel stream back to packed 24-bit RGB.
//   The pipeline is fixed-latency, takes one pixel per clock and has no backpressure.
//   Each pixel carries a valid bit down the pipeline.
//   An output stage numbers the pixels of a frame in raster order and raises a sticky
//   frame-done flag when the last pixel is emitted.
//   Once the flag is set, further pixels are dropped until reset.
//
//   Timing: a pixel sampled at edge N appears on oData/oValid after edge N+4.
//     N    S1 input register
//     N+1  S2 products
//     N+2  S3 sums + rounding
//     N+3  S4 shift + clamp
//     N+4  output / pixel counter register
//
// Ports
//   clk       in   system clock, posedge
//   reset     in   synchronous, active-high
//   yccValid  in   y/cb/cr valid this cycle
//   y         in   signed luma, scaled by 2^FRAC_BITS
//   cb, cr    in   signed zero-centred chroma, scaled by 2^FRAC_BITS
//   oData     out  {R, G, B}
//   oValid    out  oData valid
//   oCol      out  column of the pixel on oData
//   oRow      out  row of the pixel on oData
//   oDone     out  last pixel of the frame emitted; sticky until reset
module ycc_to_rgb #(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int FRAC_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               yccValid,
    input  logic signed [17:0] y,
    input  logic signed [17:0] cb,
    input  logic signed [17:0] cr,
    output logic        [23:0] oData,
    output logic               oValid,
    output logic        [8:0]  oCol,
    output logic        [7:0]  oRow,
    output logic               oDone
);

    // Q2.16 conversion coefficients
    localparam logic signed [17:0] KRCR = 18'sd91881;
    localparam logic signed [17:0] KGCB = 18'sd22554;
    localparam logic signed [17:0] KGCR = 18'sd46801;
    localparam logic signed [17:0] KBCB = 18'sd116130;

    // Sums carry FRAC_BITS + 16 fractional bits.
    // Adding half an LSB before the arithmetic shift rounds to nearest.
    localparam int                 SHIFT = FRAC_BITS + 16;
    localparam logic signed [39:0] ROUND = 40'sd1 <<< (SHIFT - 1);

    localparam logic [8:0] LAST_COL = 9'(WIDTH - 1);
    localparam logic [7:0] LAST_ROW = 8'(HEIGHT - 1);

    // S1
    logic               r_s1_valid;
    logic signed [17:0] r_s1_y, r_s1_cb, r_s1_cr;
    // S2
    logic               r_s2_valid;
    logic signed [35:0] r_s2_y, r_s2_p_rcr, r_s2_p_gcb, r_s2_p_gcr, r_s2_p_bcb;
    // S3
    logic               r_s3_valid;
    logic signed [39:0] r_s3_r, r_s3_g, r_s3_b;
    // S4
    logic               r_s4_valid;
    logic        [23:0] r_s4_data;
    // position of the next pixel to be emitted
    logic        [8:0]  r_col;
    logic        [7:0]  r_row;

    logic signed [39:0] w_s3_r, w_s3_g, w_s3_b;
    logic signed [39:0] w_s4_r, w_s4_g, w_s4_b;
    logic               w_last_pix;

    function automatic logic [7:0] clamp8(input logic signed [39:0] v);
        if (v < 40'sd0)
            return 8'd0;
        else if (v > 40'sd255)
            return 8'd255;
        else
            return 8'(v);
    endfunction

    always_comb begin
        w_s3_r = 40'(r_s2_y) + 40'(r_s2_p_rcr) + ROUND;
        w_s3_g = 40'(r_s2_y) - 40'(r_s2_p_gcb) - 40'(r_s2_p_gcr) + ROUND;
        w_s3_b = 40'(r_s2_y) + 40'(r_s2_p_bcb) + ROUND;
        w_s4_r = r_s3_r >>> SHIFT;
        w_s4_g = r_s3_g >>> SHIFT;
        w_s4_b = r_s3_b >>> SHIFT;
        w_last_pix = (r_col == LAST_COL) && (r_row == LAST_ROW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_y     <= '0;
            r_s1_cb    <= '0;
            r_s1_cr    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_p_rcr <= '0;
            r_s2_p_gcb <= '0;
            r_s2_p_gcr <= '0;
            r_s2_p_bcb <= '0;
            r_s3_valid <= 1'b0;
            r_s3_r     <= '0;
            r_s3_g     <= '0;
            r_s3_b     <= '0;
            r_s4_valid <= 1'b0;
            r_s4_data  <= '0;
        end else begin
            r_s1_valid <= yccValid;
            r_s1_y     <= y;
            r_s1_cb    <= cb;
            r_s1_cr    <= cr;

            // Luma is brought to the same 2^16 scale as the coefficient products.
            r_s2_valid <= r_s1_valid;
            r_s2_y     <= 36'(r_s1_y) <<< 16;
            r_s2_p_rcr <= 36'(r_s1_cr) * 36'(KRCR);
            r_s2_p_gcb <= 36'(r_s1_cb) * 36'(KGCB);
            r_s2_p_gcr <= 36'(r_s1_cr) * 36'(KGCR);
            r_s2_p_bcb <= 36'(r_s1_cb) * 36'(KBCB);

            r_s3_valid <= r_s2_valid;
            r_s3_r     <= w_s3_r;
            r_s3_g     <= w_s3_g;
            r_s3_b     <= w_s3_b;

            r_s4_valid <= r_s3_valid;
            r_s4_data  <= {clamp8(w_s4_r), clamp8(w_s4_g), clamp8(w_s4_b)};
        end
    end

    // Output stage.
    // Once oDone is set, pixels arriving behind the last one are dropped
    // and the counters stay frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            oData  <= '0;
            oValid <= 1'b0;
            oCol   <= '0;
            oRow   <= '0;
            oDone  <= 1'b0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (r_s4_valid && !oDone) begin
            oValid <= 1'b1;
            oData  <= r_s4_data;
            oCol   <= r_col;
            oRow   <= r_row;
            if (w_last_pix) begin
                oDone <= 1'b1;
                r_col <= '0;
                r_row <= '0;
            end else if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + 8'd1;
            end else begin
                r_col <= r_col + 9'd1;
            end
        end else begin
            oValid <= 1'b0;
        end
    end

endmodule
